alu_seq: RTL
============

# alu_seq

Registered, handshaked successor to the combinational 16-bit ALU, generalised to any `BIT_WIDTH`. It keeps a processor-status flag register, so `ADDC` consumes the stored carry instead of a port input. It adds an optional multi-cycle iterative multiply. It sits between register-file read and writeback in the datapath, using valid/ready on both sides.

## Interface
Parameters:
- `BIT_WIDTH`, default 16: operand/result width; must be ≥ 4.
- `OPCODE_WIDTH`, default 8: opcode width.
- `FLAG_WIDTH`, default 5: flag register width. Bit index: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: operation offered.
- `in_ready` out 1: operation accepted on an edge where `in_valid && in_ready`.
- `Opcode` in `OPCODE_WIDTH`: operation; sampled on accept.
- `Rdest` in `BIT_WIDTH`: destination operand; sampled on accept.
- `Rsrc_Imm` in `BIT_WIDTH`: source or pre-extended immediate; sampled on accept.
- `out_valid` out 1: `Result`/`Flags` valid.
- `out_ready` in 1: consumer takes the result.
- `Result` out `BIT_WIDTH`: registered result.
- `Flags` out `FLAG_WIDTH`: registered status flags (PSR).

## Operation
- Opcodes (hex), where `x` means the low nibble is don't-care:
  - `05`/`5x` ADD: C=unsigned carry, F=signed overflow.
  - `06`/`6x` ADDU: C only.
  - `07`/`7x` ADDC: Rdest+Rsrc+stored C; C and F updated.
  - `09`/`9x` SUB: F=signed overflow, C=borrow.
  - `0B`/`Bx` CMP: Result=Rdest. Z=equal, L=Rdest<Rsrc unsigned, N=Rdest<Rsrc signed.
  - `01` AND, `02` OR, `03` XOR, `04` NOT(Rdest): flags unchanged.
  - `84` LSH: Rdest<<Rsrc_Imm.
  - `88` RSH: logical right.
  - `86` ARSH: arithmetic right.
  - `0E` MUL: multi-cycle, gated by the macro below.
  - `00` NOP: Result=Rdest.
- Flags not listed for an opcode keep their value.
- Unlisted opcodes: Result=0, flags unchanged, still complete with `out_valid`.
- Arithmetic is modulo 2^`BIT_WIDTH`.
- Shift amount is `Rsrc_Imm` unsigned. Amount ≥ `BIT_WIDTH`: LSH/RSH give 0; ARSH gives all copies of the sign bit.
- MUL: Result = low `BIT_WIDTH` bits of the unsigned product. C=1 iff the high half is nonzero; other flags unchanged.
- FSM states:
  - IDLE: accept a single-cycle op → load output regs → stay IDLE. Accept MUL → MUL.
  - MUL: count `BIT_WIDTH` iterations → load output regs → IDLE.
- `in_ready` = (state==IDLE) && (!`out_valid` || `out_ready`).
- `out_valid` sets on the load edge. It clears on an edge with `out_ready` and no new load.
- `Result` and `Flags` change only on a load edge.
- Reset value of every output is 0. Reset also clears the state to IDLE, the MUL counter, and the flag register.

## Timing
- Single-cycle op accepted at edge k: `out_valid`, `Result`, `Flags` valid after edge k.
- Back-to-back single-cycle ops sustain 1 op/clock while `out_ready`=1.
- MUL accepted at edge k: result loads at edge k+`BIT_WIDTH`; `in_ready`=0 for the edges in between.
- ADDC accepted on the edge that loads the previous op's flags uses the newly loaded C, i.e. the flag write is seen by the next accepted op.
- Output held stable while `out_valid && !out_ready`.
- Reset asserted mid-MUL: the multiply is aborted with no output and takes effect immediately (async). The first accept is possible on the first edge after `reset` deasserts.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state, counter and multiplier are instantiated; `0E` behaves as above.
- Undefined: no MUL state or logic; `0E` decodes as NOP (Result=Rdest, flags unchanged, one cycle).

## Structure
- Package `alu_pkg`:
  - opcode constants, including nibble-prefix immediate forms;
  - flag bit indices;
  - FSM state encoding;
  - shift-amount width `$clog2(BIT_WIDTH)` helper.
- Sub-module `alu_mul_iter`: shift-add multiplier with `start`/`done` ports. It is the only natural split, and it exists only under `ALU_SEQ_MUL_EN`.

## Test plan
- ADD Rdest=0x7FFF, Rsrc=0x0001, `out_ready`=1 → one cycle later Result=0x8000, F=1, C=0, `out_valid`=1.
- ADDU 0xFFFF+0x0001 → Result=0x0000, C=1. Next ADDC 0x0001+0x0002 → Result=0x0004, C=0.
- CMP Rdest=0x0003, Rsrc=0xFFFF → Result=0x0003, L=1, N=0, Z=0. Then ARSH 0x8000 by 20 → Result=0xFFFF.
- MUL 0x0100×0x0100 (macro on) → `in_ready`=0 for 16 edges, then Result=0x0000, C=1. Macro off → Result=0x0100 after one cycle.
- `out_ready`=0 for 3 cycles after an AND result → Result/Flags held, `in_ready`=0. Next queued op accepted on the edge where `out_ready` returns to 1.
- `reset` pulsed 5 cycles into a MUL → immediately `out_valid`=0, Result=0, Flags=0. ADD 2+3 after release → Result=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// FSM states, and the opcode decoder.
package alu_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ARSH = 8'h86;
  localparam logic [7:0] OP_RSH  = 8'h88;

  // High-nibble prefixes of the immediate forms; the low nibble is don't-care.
  localparam logic [3:0] PFX_ADD  = 4'h5;
  localparam logic [3:0] PFX_ADDU = 4'h6;
  localparam logic [3:0] PFX_ADDC = 4'h7;
  localparam logic [3:0] PFX_SUB  = 4'h9;
  localparam logic [3:0] PFX_CMP  = 4'hB;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef enum logic [3:0] {
    OPC_NOP, OPC_AND, OPC_OR, OPC_XOR, OPC_NOT,
    OPC_ADD, OPC_ADDU, OPC_ADDC, OPC_SUB, OPC_CMP,
    OPC_LSH, OPC_RSH, OPC_ARSH, OPC_MUL, OPC_BAD
  } op_e;

  function automatic int shamt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic op_e decode_op(input logic [7:0] op);
    op_e kind;
    kind = OPC_BAD;
    case (op)
      OP_NOP:  kind = OPC_NOP;
      OP_AND:  kind = OPC_AND;
      OP_OR:   kind = OPC_OR;
      OP_XOR:  kind = OPC_XOR;
      OP_NOT:  kind = OPC_NOT;
      OP_ADD:  kind = OPC_ADD;
      OP_ADDU: kind = OPC_ADDU;
      OP_ADDC: kind = OPC_ADDC;
      OP_SUB:  kind = OPC_SUB;
      OP_CMP:  kind = OPC_CMP;
      OP_MUL:  kind = OPC_MUL;
      OP_LSH:  kind = OPC_LSH;
      OP_ARSH: kind = OPC_ARSH;
      OP_RSH:  kind = OPC_RSH;
      default: begin
        case (op[7:4])
          PFX_ADD:  kind = OPC_ADD;
          PFX_ADDU: kind = OPC_ADDU;
          PFX_ADDC: kind = OPC_ADDC;
          PFX_SUB:  kind = OPC_SUB;
          PFX_CMP:  kind = OPC_CMP;
          default:  kind = OPC_BAD;
        endcase
      end
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per clock,
// BIT_WIDTH clocks after start. Present only when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_iter #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BIT_WIDTH-1:0]   a,
  input  logic [BIT_WIDTH-1:0]   b,
  output logic                   done,
  output logic [2*BIT_WIDTH-1:0] product
);

  localparam int CW = $clog2(BIT_WIDTH + 1);

  logic                   busy_q, busy_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*BIT_WIDTH-1:0] prod_q, prod_d;
  logic [BIT_WIDTH:0]     partial;

  // prod holds {high accumulator, remaining multiplier bits}; each step adds
  // the multiplicand into the high half when the low bit is set, then shifts.
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    done    = 1'b0;
    partial = {1'b0, prod_q[2*BIT_WIDTH-1:BIT_WIDTH]} +
              (prod_q[0] ? {1'b0, mcand_q} : '0);
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = a;
      prod_d  = {{BIT_WIDTH{1'b0}}, b};
    end else if (busy_q) begin
      prod_d = {partial, prod_q[BIT_WIDTH-1:1]};
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == CW'(BIT_WIDTH - 1)) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  // The product is presented on the completing edge so the caller can load it then.
  assign product = prod_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered, valid/ready ALU with a persistent flag register (PSR).
// Define ALU_SEQ_MUL_EN to build the multi-cycle MUL; otherwise MUL decodes as NOP.
module alu_seq
  import alu_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] Opcode,
  input  logic [BIT_WIDTH-1:0]    Rdest,
  input  logic [BIT_WIDTH-1:0]    Rsrc_Imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIT_WIDTH-1:0]    Result,
  output logic [FLAG_WIDTH-1:0]   Flags
);

  localparam int MSB = BIT_WIDTH - 1;
  localparam int SHW = shamt_width(BIT_WIDTH);

  logic [BIT_WIDTH-1:0]  result_q, result_d;
  logic [FLAG_WIDTH-1:0] flags_q, flags_d;
  logic                  out_valid_q, out_valid_d;

  logic                  accept;
  logic                  load;
  logic [BIT_WIDTH-1:0]  load_res;
  logic [FLAG_WIDTH-1:0] load_flags;

  op_e                   op_kind;
  logic [BIT_WIDTH-1:0]  a, b;
  logic [BIT_WIDTH-1:0]  alu_res;
  logic [FLAG_WIDTH-1:0] alu_flags;
  logic [BIT_WIDTH:0]    sum, diff;
  logic                  carry_in;
  logic                  shift_big;
  logic [SHW-1:0]        shamt;

  assign a = Rdest;
  assign b = Rsrc_Imm;

  always_comb begin
    op_kind = OPC_BAD;
    if ((Opcode >> 8) == '0) op_kind = decode_op(Opcode[7:0]);
  end

  // Single-cycle datapath, evaluated on the offered operands and the current PSR.
  always_comb begin
    alu_res   = '0;
    alu_flags = flags_q;
    carry_in  = (op_kind == OPC_ADDC) ? flags_q[FLAG_C] : 1'b0;
    sum       = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
    diff      = {1'b0, a} - {1'b0, b};
    shift_big = (b >= BIT_WIDTH'(BIT_WIDTH));
    shamt     = b[SHW-1:0];
    case (op_kind)
      OPC_AND: alu_res = a & b;
      OPC_OR:  alu_res = a | b;
      OPC_XOR: alu_res = a ^ b;
      OPC_NOT: alu_res = ~a;
      OPC_ADD, OPC_ADDC: begin
        alu_res           = sum[MSB:0];
        alu_flags[FLAG_C] = sum[BIT_WIDTH];
        alu_flags[FLAG_F] = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OPC_ADDU: begin
        alu_res           = sum[MSB:0];
        alu_flags[FLAG_C] = sum[BIT_WIDTH];
      end
      OPC_SUB: begin
        alu_res           = diff[MSB:0];
        alu_flags[FLAG_C] = diff[BIT_WIDTH];
        alu_flags[FLAG_F] = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OPC_CMP: begin
        alu_res           = a;
        alu_flags[FLAG_Z] = (a == b);
        alu_flags[FLAG_L] = (a < b);
        alu_flags[FLAG_N] = ($signed(a) < $signed(b));
      end
      OPC_LSH:  alu_res = shift_big ? '0 : (a << shamt);
      OPC_RSH:  alu_res = shift_big ? '0 : (a >> shamt);
      OPC_ARSH: alu_res = shift_big ? {BIT_WIDTH{a[MSB]}} : $unsigned($signed(a) >>> shamt);
      OPC_NOP, OPC_MUL: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  state_e                 state_q, state_d;
  logic                   is_mul;
  logic                   mul_start;
  logic                   mul_done;
  logic [2*BIT_WIDTH-1:0] mul_prod;

  assign is_mul    = (op_kind == OPC_MUL);
  assign mul_start = accept && is_mul;
  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);

  alu_mul_iter #(.BIT_WIDTH(BIT_WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (Rdest),
    .b       (Rsrc_Imm),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    load_res   = alu_res;
    load_flags = alu_flags;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul) state_d = ST_MUL;
          else        load    = 1'b1;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          load               = 1'b1;
          load_res           = mul_prod[MSB:0];
          load_flags         = flags_q;
          load_flags[FLAG_C] = |mul_prod[2*BIT_WIDTH-1:BIT_WIDTH];
          state_d            = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    load       = accept;
    load_res   = alu_res;
    load_flags = alu_flags;
  end
`endif

  // A load always wins over a consume, so back-to-back ops keep out_valid high.
  always_comb begin
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    if (load) begin
      result_d    = load_res;
      flags_d     = load_flags;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Result    = result_q;
  assign Flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule
